// File: rtl/pooling_2x2_param_if.sv
// Bus bundle for pooling_2x2_param.
//
// Groups the source-buffer read port, the four window input words, the frame
// control inputs and the result/save port into one interface.
//   slave  : the pooling block (drives read requests, results and done pulses)
//   master : the surrounding system (drives window data, frame start, mode, stall)
//
// Signals
//   input_data_even_even/_even_odd/_odd_even/_odd_odd : 2x2 window words, CH*DATA_W each
//   pixel_store_done       : one-cycle frame start pulse
//   pool_mode              : 0 = max, 1 = average
//   stall                  : hold request
//   read_pixel_signal      : read request to the source buffer
//   read_row_addr/_col_addr: output-grid coordinate of the window being read
//   save_enable            : output_data/output_row/output_col valid
//   output_row/output_col  : coordinate of output_data
//   output_data            : pooled word, CH*DATA_W
//   pipeline_calculation_done : pulse while saving output (0,1)
//   calculation_done       : pulse on the last save of the frame
interface pooling_2x2_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH     = 8,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned WordW = CH * DATA_W;

  logic [WordW-1:0]  input_data_even_even;
  logic [WordW-1:0]  input_data_even_odd;
  logic [WordW-1:0]  input_data_odd_even;
  logic [WordW-1:0]  input_data_odd_odd;
  logic              pixel_store_done;
  logic              pool_mode;
  logic              stall;

  logic              read_pixel_signal;
  logic [ADDR_W-1:0] read_row_addr;
  logic [ADDR_W-1:0] read_col_addr;
  logic              save_enable;
  logic [ADDR_W-1:0] output_row;
  logic [ADDR_W-1:0] output_col;
  logic [WordW-1:0]  output_data;
  logic              pipeline_calculation_done;
  logic              calculation_done;

  modport slave (
    input  input_data_even_even,
    input  input_data_even_odd,
    input  input_data_odd_even,
    input  input_data_odd_odd,
    input  pixel_store_done,
    input  pool_mode,
    input  stall,
    output read_pixel_signal,
    output read_row_addr,
    output read_col_addr,
    output save_enable,
    output output_row,
    output output_col,
    output output_data,
    output pipeline_calculation_done,
    output calculation_done
  );

  modport master (
    output input_data_even_even,
    output input_data_even_odd,
    output input_data_odd_even,
    output input_data_odd_odd,
    output pixel_store_done,
    output pool_mode,
    output stall,
    input  read_pixel_signal,
    input  read_row_addr,
    input  read_col_addr,
    input  save_enable,
    input  output_row,
    input  output_col,
    input  output_data,
    input  pipeline_calculation_done,
    input  calculation_done
  );
endinterface

// File: rtl/pooling_2x2_param.sv
// 2x2 max / average pooling engine over a MAP_DIM x MAP_DIM output map.
//
// A frame starts on pixel_store_done while idle. The block scans the output grid
// in raster order, issuing one window read per unstalled cycle. The source buffer
// returns the four window words one cycle after the read; they are registered and
// the pooled result is formed combinationally from those registers, so each save
// trails its read by two unstalled cycles. stall freezes the whole pipeline.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pooling_2x2_param_if.slave (window data in, frame control in,
//          read request / result / done pulses out)
module pooling_2x2_param #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CH      = 8,
  parameter int unsigned MAP_DIM = 8,
  parameter int unsigned ADDR_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  pooling_2x2_param_if.slave  bus
);

  localparam int unsigned WordW = CH * DATA_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] ENABLE = 2'd2;

  localparam logic [ADDR_W-1:0] Last = ADDR_W'(MAP_DIM - 1);
  localparam logic [ADDR_W-1:0] One  = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic              fill_q, fill_d;
  logic              mode_q, mode_d;
  logic              rd_active_q, rd_active_d;
  logic [ADDR_W-1:0] rd_row_q, rd_row_d;
  logic [ADDR_W-1:0] rd_col_q, rd_col_d;
  logic [ADDR_W-1:0] out_row_q, out_row_d;
  logic [ADDR_W-1:0] out_col_q, out_col_d;
  logic [WordW-1:0]  ee_q, ee_d;
  logic [WordW-1:0]  eo_q, eo_d;
  logic [WordW-1:0]  oe_q, oe_d;
  logic [WordW-1:0]  oo_q, oo_d;

  logic              idle;
  logic              run;
  logic              save;
  logic              rd_last;
  logic              out_last;
  logic              frame_end;
  logic [WordW-1:0]  pooled;

  assign idle      = (state_q == IDLE);
  assign run       = !idle && !bus.stall;
  assign save      = (state_q == ENABLE) && !bus.stall;
  assign rd_last   = (rd_row_q == Last) && (rd_col_q == Last);
  assign out_last  = (out_row_q == Last) && (out_col_q == Last);
  assign frame_end = save && out_last;

  // Frame control
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        fill_d = 1'b0;
        if (bus.pixel_store_done) begin
          state_d = FILL;
          mode_d  = bus.pool_mode;
        end
      end
      FILL: begin
        // Two unstalled cycles: read issued, then data registered.
        if (!bus.stall) begin
          if (fill_q) begin
            state_d = ENABLE;
            fill_d  = 1'b0;
          end else begin
            fill_d = 1'b1;
          end
        end
      end
      ENABLE: begin
        if (frame_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fill_d  = 1'b0;
      end
    endcase
  end

  // Read address scan; holds the final address once the whole map is issued.
  always_comb begin
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    rd_active_d = rd_active_q;
    if (idle || frame_end) begin
      rd_row_d    = '0;
      rd_col_d    = '0;
      rd_active_d = idle && bus.pixel_store_done;
    end else if (run && rd_active_q) begin
      if (rd_last) begin
        rd_active_d = 1'b0;
      end else if (rd_col_q == Last) begin
        rd_col_d = '0;
        rd_row_d = rd_row_q + One;
      end else begin
        rd_col_d = rd_col_q + One;
      end
    end
  end

  // Output coordinate scan, one step per save.
  always_comb begin
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (idle || frame_end) begin
      out_row_d = '0;
      out_col_d = '0;
    end else if (save) begin
      if (out_col_q == Last) begin
        out_col_d = '0;
        out_row_d = out_row_q + One;
      end else begin
        out_col_d = out_col_q + One;
      end
    end
  end

  // Window registers: cleared while idle, frozen while stalled.
  always_comb begin
    ee_d = ee_q;
    eo_d = eo_q;
    oe_d = oe_q;
    oo_d = oo_q;
    if (idle) begin
      ee_d = '0;
      eo_d = '0;
      oe_d = '0;
      oo_d = '0;
    end else if (!bus.stall) begin
      ee_d = bus.input_data_even_even;
      eo_d = bus.input_data_even_odd;
      oe_d = bus.input_data_odd_even;
      oo_d = bus.input_data_odd_odd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= 1'b0;
      mode_q      <= 1'b0;
      rd_active_q <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      ee_q        <= '0;
      eo_q        <= '0;
      oe_q        <= '0;
      oo_q        <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
      rd_active_q <= rd_active_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      ee_q        <= ee_d;
      eo_q        <= eo_d;
      oe_q        <= oe_d;
      oo_q        <= oo_d;
    end
  end

  // Per-channel pooling datapath
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] s0, s1, s2, s3;
    logic signed [DATA_W-1:0] m01, m23, mx;
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W+1:0] quarter;

    assign s0 = ee_q[c*DATA_W +: DATA_W];
    assign s1 = eo_q[c*DATA_W +: DATA_W];
    assign s2 = oe_q[c*DATA_W +: DATA_W];
    assign s3 = oo_q[c*DATA_W +: DATA_W];

    assign m01 = (s0 > s1) ? s0 : s1;
    assign m23 = (s2 > s3) ? s2 : s3;
    assign mx  = (m01 > m23) ? m01 : m23;

    // Two guard bits hold the sum of four samples exactly; the arithmetic shift
    // floors toward minus infinity and the quotient always fits DATA_W bits.
    assign sum = {{2{s0[DATA_W-1]}}, s0} + {{2{s1[DATA_W-1]}}, s1}
               + {{2{s2[DATA_W-1]}}, s2} + {{2{s3[DATA_W-1]}}, s3};
    assign quarter = sum >>> 2;

    assign pooled[c*DATA_W +: DATA_W] = mode_q ? quarter[DATA_W-1:0] : mx;
  end

  assign bus.read_pixel_signal         = run && rd_active_q;
  assign bus.read_row_addr             = rd_row_q;
  assign bus.read_col_addr             = rd_col_q;
  assign bus.save_enable               = save;
  assign bus.output_row                = out_row_q;
  assign bus.output_col                = out_col_q;
  assign bus.output_data               = idle ? '0 : pooled;
  assign bus.pipeline_calculation_done = save && (out_row_q == '0) && (out_col_q == One);
  assign bus.calculation_done          = frame_end;

endmodule
